// File: rtl/freq_disp_ctrl_if.sv
// freq_disp_ctrl_if: conversion request and display outputs for freq_disp_ctrl
interface freq_disp_ctrl_if;
    logic        start;
    logic [26:0] count;
    logic [1:0]  unit;
    logic [3:0]  hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0;
    logic [7:0]  dp_out;
    logic        busy;
    logic        done;
    modport master (output start, count, unit,
                    input hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0, dp_out, busy, done);
    modport slave  (input start, count, unit,
                    output hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0, dp_out, busy, done);
endinterface

// File: rtl/freq_disp_ctrl.sv
// freq_disp_ctrl: sequential double-dabble of a 27-bit Hz count into 8 BCD display digits
module freq_disp_ctrl (
    input logic             clk,
    input logic             rst,
    freq_disp_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;
    state_t      state, state_nx;
    logic [26:0] bin;
    logic [31:0] bcd, bcd_adj, disp;
    logic [4:0]  bit_cnt;
    logic [1:0]  unit_q;
    logic        ovf_q, done_q;
    logic [7:0]  dp, dp_nx;
    for (genvar i = 0; i < 8; i++) begin : g_adj
        assign bcd_adj[4*i+:4] = bcd[4*i+:4] >= 4'd5 ? bcd[4*i+:4] + 4'd3 : bcd[4*i+:4];
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nx;
    always_comb begin
        state_nx = state;
        state_nx = state == IDLE ? (bus.start ? CONV : IDLE) :
                   state == CONV ? (bit_cnt == 5'd1 ? UPDATE : CONV) : IDLE;
    end
    always_comb begin
        dp_nx = 8'hFF;
        dp_nx = ovf_q ? 8'hFF : unit_q == 2'd1 ? 8'hF7 : unit_q == 2'd2 ? 8'hBF : 8'hFF;
    end
    // Display registers load only in UPDATE so the scan driver never sees a partial result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {bcd, bin, bit_cnt, unit_q, ovf_q, disp, done_q} <= '0;
            dp <= 8'hFF;
        end else begin
            done_q <= state == UPDATE;
            if (state == IDLE && bus.start) begin
                bin     <= bus.count;
                bcd     <= '0;
                bit_cnt <= 5'd27;
                unit_q  <= bus.unit;
                ovf_q   <= bus.count > 27'd99_999_999;
            end else if (state == CONV) begin
                {bcd, bin} <= {bcd_adj, bin} << 1;
                bit_cnt    <= bit_cnt - 5'd1;
            end else if (state == UPDATE) begin
                disp <= ovf_q ? '1 : bcd;
                dp   <= dp_nx;
            end
        end
    end
    assign {bus.hex7, bus.hex6, bus.hex5, bus.hex4, bus.hex3, bus.hex2, bus.hex1, bus.hex0} = disp;
    assign bus.dp_out = dp;
    assign bus.busy   = state != IDLE;
    assign bus.done   = done_q;
endmodule
